// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared pipeline widths, ALU operation classes and funct codes
package id_ex_stage_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2a;
endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// forward_unit: picks the freshest value of one source register for the EX stage
//   i_src      registered source specifier
//   i_reg_val  registered register-file value
//   i_exmem_*  EX/MEM writeback source (highest priority)
//   i_memwb_*  MEM/WB writeback source
//   o_val      forwarded operand; register 0 is never forwarded
module forward_unit import id_ex_stage_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [DATA_W-1:0] i_reg_val,
  input  logic              i_exmem_regwrite,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic [DATA_W-1:0] i_exmem_result,
  input  logic              i_memwb_regwrite,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic [DATA_W-1:0] i_memwb_wdata,
  output logic [DATA_W-1:0] o_val
);
  logic w_nz, w_hit_exmem, w_hit_memwb;
  assign w_nz        = |i_src;
  assign w_hit_exmem = w_nz & i_exmem_regwrite & (i_exmem_rd == i_src);
  assign w_hit_memwb = w_nz & i_memwb_regwrite & (i_memwb_rd == i_src);
  assign o_val = w_hit_exmem ? i_exmem_result : w_hit_memwb ? i_memwb_wdata : i_reg_val;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall detection and operand forwarding
//   id_*        decoded instruction from ID, captured on each rising edge
//   flush       squash the instruction entering EX (bubble)
//   exmem_*/memwb_*  forwarding sources for the registered rs/rt
//   stall_req   combinational load-use hazard; also forces a bubble here
//   alu_*       operation and operands for the ALU
//   ex_*        registered destination, store data and controls for EX/MEM
module id_ex_stage import id_ex_stage_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [5:0]        id_funct,
  input  logic [1:0]        id_aluop,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [15:0]       id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_alusrc,
  input  logic              id_regdst,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_regwrite,
  input  logic              id_memtoreg,
  input  logic              flush,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_wdata,
  output logic              stall_req,
  output logic [5:0]        alu_instruction,
  output logic [1:0]        alu_aluop,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_valid,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_regwrite,
  output logic              ex_memtoreg
);
  logic              r_valid, r_memread, r_memwrite, r_regwrite, r_memtoreg, r_alusrc;
  logic [5:0]        r_funct;
  logic [1:0]        r_aluop;
  logic [DATA_W-1:0] r_rdata1, r_rdata2, r_imm;
  logic [REG_AW-1:0] r_rs, r_rt, r_dest;
  logic              w_load, w_live;
  logic [DATA_W-1:0] w_imm_sx, w_fwd_rs, w_fwd_rt;
  assign stall_req = r_valid & r_memread & ((r_rt == id_rs) | (r_rt == id_rt)) & id_valid;
  assign w_load    = ~flush & ~stall_req;
  // controls of an invalid instruction are captured as 0 so nothing downstream acts on it
  assign w_live    = w_load & id_valid;
  assign w_imm_sx  = {{(DATA_W-16){id_imm[15]}}, id_imm};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_valid    <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_alusrc   <= 1'b0;
      r_funct    <= '0;
      r_aluop    <= '0;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_dest     <= '0;
    end else begin
      r_valid    <= w_live;
      r_memread  <= w_live & id_memread;
      r_memwrite <= w_live & id_memwrite;
      r_regwrite <= w_live & id_regwrite;
      r_memtoreg <= w_live & id_memtoreg;
      r_alusrc   <= w_load & id_alusrc;
      r_funct    <= w_load ? id_funct : '0;
      r_aluop    <= w_load ? id_aluop : '0;
      r_rdata1   <= w_load ? id_rdata1 : '0;
      r_rdata2   <= w_load ? id_rdata2 : '0;
      r_imm      <= w_load ? w_imm_sx : '0;
      r_rs       <= w_load ? id_rs : '0;
      r_rt       <= w_load ? id_rt : '0;
      r_dest     <= w_load ? (id_regdst ? id_rd : id_rt) : '0;
    end
  forward_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .i_src(r_rs), .i_reg_val(r_rdata1),
    .i_exmem_regwrite(exmem_regwrite), .i_exmem_rd(exmem_rd), .i_exmem_result(exmem_result),
    .i_memwb_regwrite(memwb_regwrite), .i_memwb_rd(memwb_rd), .i_memwb_wdata(memwb_wdata),
    .o_val(w_fwd_rs)
  );
  forward_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .i_src(r_rt), .i_reg_val(r_rdata2),
    .i_exmem_regwrite(exmem_regwrite), .i_exmem_rd(exmem_rd), .i_exmem_result(exmem_result),
    .i_memwb_regwrite(memwb_regwrite), .i_memwb_rd(memwb_rd), .i_memwb_wdata(memwb_wdata),
    .o_val(w_fwd_rt)
  );
  assign alu_instruction = r_funct;
  assign alu_aluop       = r_aluop;
  assign alu_data1       = w_fwd_rs;
  assign alu_data2       = r_alusrc ? r_imm : w_fwd_rt;
  assign ex_store_data   = w_fwd_rt;
  assign ex_dest         = r_dest;
  assign ex_valid        = r_valid;
  assign ex_memread      = r_memread;
  assign ex_memwrite     = r_memwrite;
  assign ex_regwrite     = r_regwrite;
  assign ex_memtoreg     = r_memtoreg;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: random and directed checks of id_ex_stage against a behavioural model
module tb_id_ex_stage;
  logic clk = 1'b0, reset;
  logic id_valid, id_alusrc, id_regdst, id_memread, id_memwrite, id_regwrite, id_memtoreg, flush;
  logic [5:0] id_funct;
  logic [1:0] id_aluop;
  logic [31:0] id_rdata1, id_rdata2, exmem_result, memwb_wdata;
  logic [15:0] id_imm;
  logic [4:0] id_rs, id_rt, id_rd, exmem_rd, memwb_rd;
  logic exmem_regwrite, memwb_regwrite;
  logic stall_req, ex_valid, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
  logic [5:0] alu_instruction;
  logic [1:0] alu_aluop;
  logic [31:0] alu_data1, alu_data2, ex_store_data;
  logic [4:0] ex_dest;
  always #5 clk = ~clk;
  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_funct(id_funct), .id_aluop(id_aluop),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
    .stall_req(stall_req), .alu_instruction(alu_instruction), .alu_aluop(alu_aluop),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg)
  );
  typedef struct packed {
    logic v, mr, mw, rw, mt, as;
    logic [5:0] fn;
    logic [1:0] op;
    logic [31:0] d1, d2, imm;
    logic [4:0] rs, rt, dst;
  } ex_t;
  ex_t m, nxt;
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] regval);
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == r) return exmem_result;
    if (memwb_regwrite && memwb_rd != 0 && memwb_rd == r) return memwb_wdata;
    return regval;
  endfunction
  function automatic logic exp_stall();
    return m.v && m.mr && id_valid && (m.rt == id_rs || m.rt == id_rt);
  endfunction
  function automatic ex_t model_next();
    ex_t n;
    n = '0;
    if (flush || exp_stall()) return n;
    n.v = id_valid;
    n.mr = id_valid & id_memread;
    n.mw = id_valid & id_memwrite;
    n.rw = id_valid & id_regwrite;
    n.mt = id_valid & id_memtoreg;
    n.as = id_alusrc;
    n.fn = id_funct;
    n.op = id_aluop;
    n.d1 = id_rdata1;
    n.d2 = id_rdata2;
    n.imm = 32'($signed(id_imm));
    n.rs = id_rs;
    n.rt = id_rt;
    n.dst = id_regdst ? id_rd : id_rt;
    return n;
  endfunction
  task automatic check_all(input string p);
    chk({p, "_stall"}, stall_req, exp_stall());
    chk({p, "_valid"}, ex_valid, m.v);
    chk({p, "_memread"}, ex_memread, m.mr);
    chk({p, "_memwrite"}, ex_memwrite, m.mw);
    chk({p, "_regwrite"}, ex_regwrite, m.rw);
    chk({p, "_memtoreg"}, ex_memtoreg, m.mt);
    chk({p, "_funct"}, alu_instruction, m.fn);
    chk({p, "_aluop"}, alu_aluop, m.op);
    chk({p, "_data1"}, alu_data1, fwd(m.rs, m.d1));
    chk({p, "_data2"}, alu_data2, m.as ? m.imm : fwd(m.rt, m.d2));
    chk({p, "_store"}, ex_store_data, fwd(m.rt, m.d2));
    chk({p, "_dest"}, ex_dest, m.dst);
  endtask
  task automatic tick(input string p);
    @(negedge clk);
    check_all(p);
    nxt = model_next();
    @(posedge clk);
    m = nxt;
    #1;
  endtask
  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b1;
    #1;
    m = '0;
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_regwrite", ex_regwrite, 1'b0);
    chk("rst_aluop", alu_aluop, 2'b0);
    chk("rst_dest", ex_dest, 5'd0);
    check_all("rst");
    #1 reset = 1'b0;
    nxt = model_next();
    @(posedge clk);
    m = nxt;
    #1;
  endtask
  task automatic randomize_inputs();
    id_valid = ($urandom_range(0, 7) != 0);
    id_funct = 6'($urandom);
    id_aluop = 2'($urandom_range(0, 2));
    id_rdata1 = $urandom;
    id_rdata2 = $urandom;
    id_imm = 16'($urandom);
    id_rs = 5'($urandom_range(0, 3));
    id_rt = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(0, 7));
    {id_alusrc, id_regdst, id_memwrite, id_regwrite, id_memtoreg} = 5'($urandom);
    id_memread = ($urandom_range(0, 2) == 0);
    flush = ($urandom_range(0, 9) == 0);
    exmem_regwrite = 1'($urandom);
    exmem_rd = 5'($urandom_range(0, 3));
    exmem_result = $urandom;
    memwb_regwrite = 1'($urandom);
    memwb_rd = 5'($urandom_range(0, 3));
    memwb_wdata = $urandom;
  endtask
  initial begin
    reset = 1'b1;
    {id_valid, id_alusrc, id_regdst, id_memread, id_memwrite, id_regwrite, id_memtoreg, flush} = '0;
    {id_funct, id_aluop, id_rdata1, id_rdata2, id_imm, id_rs, id_rt, id_rd} = '0;
    {exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_wdata} = '0;
    m = '0;
    #2;
    check_all("init");
    reset = 1'b0;
    @(posedge clk);
    #1;
    id_valid = 1; id_rdata1 = 2; id_rdata2 = 2; id_aluop = 2'b10; id_funct = 6'h20;
    id_regdst = 1; id_rd = 3; id_rs = 1; id_rt = 2;
    tick("rtype_load");
    chk("rtype_d1", alu_data1, 32'd2);
    chk("rtype_d2", alu_data2, 32'd2);
    chk("rtype_fn", alu_instruction, 32'h20);
    chk("rtype_dest", ex_dest, 32'd3);
    id_rs = 4; id_rdata1 = 32'h11;
    tick("fwd_load");
    exmem_regwrite = 1; exmem_rd = 4; exmem_result = 7;
    memwb_regwrite = 1; memwb_rd = 4; memwb_wdata = 9;
    #1 chk("fwd_both", alu_data1, 32'd7);
    exmem_regwrite = 0;
    #1 chk("fwd_memwb", alu_data1, 32'd9);
    exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0;
    #1 chk("fwd_r0", alu_data1, 32'h11);
    {exmem_regwrite, memwb_regwrite} = '0;
    id_memread = 1; id_regwrite = 1; id_regdst = 0; id_rt = 5; id_rs = 1;
    tick("lw_load");
    id_memread = 0; id_rs = 5; id_rt = 6;
    #1 chk("lu_stall", stall_req, 1'b1);
    tick("lu_edge");
    chk("lu_bubble_v", ex_valid, 1'b0);
    chk("lu_bubble_rw", ex_regwrite, 1'b0);
    chk("lu_nostall", stall_req, 1'b0);
    tick("lu_enter");
    chk("lu_enter_v", ex_valid, 1'b1);
    id_memread = 1; id_rt = 5; id_rs = 1;
    tick("lw2_load");
    id_memread = 0; id_rs = 5; id_rt = 6; flush = 1; id_imm = 16'hFFFE; id_alusrc = 1;
    #1 chk("fs_stall", stall_req, 1'b1);
    tick("fs_edge");
    chk("fs_bubble_v", ex_valid, 1'b0);
    flush = 0;
    tick("imm_load");
    chk("imm_sx", alu_data2, 32'hFFFFFFFE);
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      if (i % 37 == 36) reset_pulse();
      else tick("rnd");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of operands and immediate.
REQ-002 Parameter REG_AW, default 5, register-specifier width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 id_valid  input  1  decode stage presents a valid instruction.
REQ-006 id_funct  input  6  instruction function field, bits [5:0].
REQ-007 id_aluop  input  2  ALU operation class: 00 add, 01 subtract, 10 decode funct.
REQ-008 id_rdata1 / id_rdata2  input  DATA_W each  register-file read values.
REQ-009 id_imm  input  16  raw immediate.
REQ-010 id_rs / id_rt / id_rd  input  REG_AW each  register specifiers.
REQ-011 id_alusrc, id_regdst, id_memread, id_memwrite, id_regwrite, id_memtoreg  input  1 each  decoded controls.
REQ-012 flush  input  1  squash the instruction entering EX.
REQ-013 exmem_regwrite, exmem_rd, exmem_result  input  1 / REG_AW / DATA_W  EX/MEM forwarding source.
REQ-014 memwb_regwrite, memwb_rd, memwb_wdata  input  1 / REG_AW / DATA_W  MEM/WB forwarding source.
REQ-015 stall_req  output  1  load-use hazard; freezes PC and IF/ID and drives this stage's bubble.
REQ-016 alu_instruction, alu_aluop, alu_data1, alu_data2  output  6 / 2 / DATA_W / DATA_W  feed the ALU-with-control.
REQ-017 ex_store_data, ex_dest, ex_valid  output  DATA_W / REG_AW / 1  to EX/MEM.
REQ-018 ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg  output  1 each  registered controls to EX/MEM.

Function
REQ-019 Latency SHALL be exactly one clock: ID inputs sampled at edge N appear on outputs after edge N.
REQ-020 Load-use hazard SHALL be asserted combinationally: stall_req = ex_valid & ex_memread & (ex_rt_q == id_rs | ex_rt_q == id_rt) & id_valid.
REQ-021 Edge priority SHALL be: reset > flush > stall_req > normal load.
REQ-022 On flush or stall_req, the register SHALL load a bubble: ex_valid, ex_memread, ex_memwrite, ex_regwrite all 0; data fields 0.
REQ-023 On normal load, all fields SHALL capture ID inputs; ex_valid = id_valid; when id_valid=0, the four control bits SHALL be captured as 0.
REQ-024 ex_dest SHALL be id_rd when id_regdst=1, else id_rt, selected at capture.
REQ-025 The immediate SHALL be sign-extended to DATA_W at capture.
REQ-026 Forwarding (combinational, from registered rs/rt): EX/MEM match with exmem_regwrite=1 selects exmem_result; else MEM/WB match with memwb_regwrite=1 selects memwb_wdata; else the registered read value.
REQ-027 Register 0 SHALL never be forwarded, regardless of regwrite.
REQ-028 When both sources match, EX/MEM SHALL win.
REQ-029 alu_data1 = forwarded rs value; alu_data2 = sign-extended immediate if alusrc_q=1, else forwarded rt value.
REQ-030 ex_store_data SHALL always be the forwarded rt value, independent of alusrc.
REQ-031 alu_instruction and alu_aluop SHALL be the registered funct and aluop unmodified.

Reset
REQ-032 While reset=1, every register SHALL be 0, so all outputs read 0 except the forwarding-muxed values, which follow REQ-026 from zeroed state.
REQ-033 Reset asserted mid-operation SHALL discard the in-flight instruction without waiting for an edge; the first edge after release performs a normal load.

Structure
REQ-034 ALUop encodings, funct codes and DATA_W/REG_AW defaults SHALL live in the shared pipeline package, shared with the ALU-with-control.
REQ-035 Forwarding selection SHALL be one sub-module, forward_unit, instanced once per operand.
REQ-036 Stall-hazard logic SHALL remain in id_ex_stage; no other sub-modules.

Verification
REQ-037 Reset: reset=1 mid-run -> ex_valid, ex_regwrite, alu_aluop, ex_dest all 0 immediately, before any clk edge.
REQ-038 Plain R-type: rdata1=2, rdata2=2, aluop=10, funct=0x20, regdst=1, rd=3 -> next cycle alu_data1=2, alu_data2=2, alu_instruction=0x20, ex_dest=3.
REQ-039 Forward priority: ex_rs=4, exmem_rd=4 result=7, memwb_rd=4 wdata=9, both regwrite=1 -> alu_data1=7; drop exmem_regwrite -> 9; rd=0 in both -> registered value.
REQ-040 Load-use: ex lw with rt=5, id_rs=5 -> stall_req=1, next cycle ex_valid=0, ex_regwrite=0; following cycle instruction enters, stall_req=0.
REQ-041 Flush with stall: flush=1 and stall_req=1 same edge -> bubble; immediate 0xFFFE with alusrc=1 -> alu_data2=0xFFFFFFFE.
